fp_divide_iterative: RTL and testbench

Single-precision IEEE-754 divider (out = in1 / in2), the inverse of `fp_multiply_pipeline`, sharing its special-case policy, flag set and rounding modes. The mantissa quotient comes from a radix-2 restoring divider that produces one bit per clock. The block accepts one operation at a time behind a `ready` handshake, so one instance serves low-throughput divide traffic in the FP ALU.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/floating_point_rounder.sv | 35 +++
 rtl/fp_divide_iterative.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_fp_divide_iterative.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision types and constants for the FP ALU blocks.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp_32b_t;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [30:0] QNAN_MAG       = 31'h7FC00000;
    localparam logic [30:0] INF_MAG        = 31'h7F800000;
    localparam logic [30:0] MAX_FINITE_MAG = 31'h7F7FFFFF;
    localparam logic [31:0] QUIET_BIT      = 32'h00400000;

    // One quotient bit per iteration: 24 significand bits plus guard, round and one spare.
    localparam int DIV_ITERS = 27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_ROUND
    } fp_div_state_t;

endpackage

// File: rtl/floating_point_rounder.sv
// Applies an IEEE rounding mode to a 23-bit mantissa given guard/round/sticky bits.
module floating_point_rounder
    import fp_pkg::*;
(
    input  logic        sign_i,
    input  logic [2:0]  rounding_mode_i,
    input  logic [22:0] mant_i,
    input  logic        guard_i,
    input  logic        round_i,
    input  logic        sticky_i,
    output logic [22:0] mant_o,
    output logic        carry_o,
    output logic        inexact_o
);

    logic any_lost;
    logic round_up;

    assign any_lost = guard_i | round_i | sticky_i;

    always_comb begin
        round_up = 1'b0;
        case (rounding_mode_i)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign_i & any_lost;
            RM_RUP:  round_up = ~sign_i & any_lost;
            RM_RMM:  round_up = guard_i;
            default: round_up = guard_i & (round_i | sticky_i | mant_i[0]);
        endcase
    end

    assign {carry_o, mant_o} = {1'b0, mant_i} + {23'd0, round_up};
    assign inexact_o         = any_lost;

endmodule

// File: rtl/fp_divide_iterative.sv
// Single-precision divider: radix-2 restoring mantissa division, one quotient bit per clock,
// fixed 28-cycle latency behind a ready handshake.
module fp_divide_iterative
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_data_in,
    output logic        ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [2:0]  rounding_mode,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        invalid_operation,
    output logic        divide_by_zero,
    output logic        valid_data_out
);

    fp_div_state_t      state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic [2:0]         rm_q, rm_d;
    logic [23:0]        div_q, div_d;
    logic [24:0]        rem_q, rem_d;
    logic [26:0]        quo_q, quo_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               special_q, special_d;
    logic [31:0]        spec_res_q, spec_res_d;
    logic               spec_inv_q, spec_inv_d;
    logic               spec_dz_q, spec_dz_d;
    logic               spec_uf_q, spec_uf_d;
    logic [31:0]        out_q, out_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inx_q, inx_d;
    logic               inv_q, inv_d;
    logic               dz_q, dz_d;
    logic               vout_q, vout_d;

    fp_32b_t a_op, b_op;
    assign a_op = in1;
    assign b_op = in2;

    // Operand classification; denormals count as zero everywhere.
    logic a_zero, a_inf, a_nan, a_qnan, a_snan, a_flush;
    logic b_zero, b_inf, b_nan, b_qnan, b_snan, b_flush;
    logic op_sign;

    assign a_zero  = (a_op.exp == 8'h00);
    assign a_flush = a_zero && (a_op.mant != 23'd0);
    assign a_inf   = (a_op.exp == 8'hFF) && (a_op.mant == 23'd0);
    assign a_nan   = (a_op.exp == 8'hFF) && (a_op.mant != 23'd0);
    assign a_qnan  = a_nan && a_op.mant[22];
    assign a_snan  = a_nan && !a_op.mant[22];
    assign b_zero  = (b_op.exp == 8'h00);
    assign b_flush = b_zero && (b_op.mant != 23'd0);
    assign b_inf   = (b_op.exp == 8'hFF) && (b_op.mant == 23'd0);
    assign b_nan   = (b_op.exp == 8'hFF) && (b_op.mant != 23'd0);
    assign b_qnan  = b_nan && b_op.mant[22];
    assign b_snan  = b_nan && !b_op.mant[22];
    assign op_sign = a_op.sign ^ b_op.sign;

    logic        sp_hit, sp_inv, sp_dz;
    logic [31:0] sp_res;

    always_comb begin
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_dz  = 1'b0;
        sp_res = 32'd0;
        if (a_qnan) begin
            sp_res = in1;
        end else if (b_qnan) begin
            sp_res = in2;
        end else if (a_snan) begin
            sp_res = in1 | QUIET_BIT;
            sp_inv = 1'b1;
        end else if (b_snan) begin
            sp_res = in2 | QUIET_BIT;
            sp_inv = 1'b1;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            sp_res = {op_sign, QNAN_MAG};
            sp_inv = 1'b1;
        end else if (a_inf) begin
            sp_res = {op_sign, INF_MAG};
        end else if (b_zero) begin
            sp_res = {op_sign, INF_MAG};
            sp_dz  = 1'b1;
        end else if (a_zero || b_inf) begin
            sp_res = {op_sign, 31'd0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // One restoring-division step.
    logic        q_bit;
    logic [24:0] rem_sub;
    assign q_bit   = (rem_q >= {1'b0, div_q});
    assign rem_sub = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;

    // Normalisation of the finished quotient.
    logic [22:0]       norm_mant;
    logic              norm_g, norm_r, norm_s;
    logic signed [9:0] norm_exp;
    logic              rem_nz;
    assign rem_nz = (rem_q != 25'd0);

    always_comb begin
        if (quo_q[26]) begin
            norm_mant = quo_q[25:3];
            norm_g    = quo_q[2];
            norm_r    = quo_q[1];
            norm_s    = quo_q[0] | rem_nz;
            norm_exp  = exp_q;
        end else begin
            norm_mant = quo_q[24:2];
            norm_g    = quo_q[1];
            norm_r    = quo_q[0];
            norm_s    = rem_nz;
            norm_exp  = exp_q - 10'sd1;
        end
    end

    logic [22:0]       rnd_mant;
    logic              rnd_carry, rnd_inexact;
    logic signed [9:0] fin_exp;

    floating_point_rounder u_rounder (
        .sign_i          (sign_q),
        .rounding_mode_i (rm_q),
        .mant_i          (norm_mant),
        .guard_i         (norm_g),
        .round_i         (norm_r),
        .sticky_i        (norm_s),
        .mant_o          (rnd_mant),
        .carry_o         (rnd_carry),
        .inexact_o       (rnd_inexact)
    );

    assign fin_exp = norm_exp + (rnd_carry ? 10'sd1 : 10'sd0);

    logic [31:0] ovf_res;
    always_comb begin
        case (rm_q)
            RM_RTZ:  ovf_res = {sign_q, MAX_FINITE_MAG};
            RM_RDN:  ovf_res = sign_q ? {1'b1, INF_MAG} : {1'b0, MAX_FINITE_MAG};
            RM_RUP:  ovf_res = sign_q ? {1'b1, MAX_FINITE_MAG} : {1'b0, INF_MAG};
            default: ovf_res = {sign_q, INF_MAG};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        rm_d       = rm_q;
        div_d      = div_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        spec_inv_d = spec_inv_q;
        spec_dz_d  = spec_dz_q;
        spec_uf_d  = spec_uf_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inx_d      = inx_q;
        inv_d      = inv_q;
        dz_d       = dz_q;
        vout_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_data_in) begin
                    state_d    = ST_DIVIDE;
                    cnt_d      = 5'd0;
                    sign_d     = op_sign;
                    rm_d       = rounding_mode;
                    div_d      = {1'b1, b_op.mant};
                    rem_d      = {2'b01, a_op.mant};
                    quo_d      = 27'd0;
                    exp_d      = $signed({2'b00, a_op.exp}) - $signed({2'b00, b_op.exp}) + 10'sd127;
                    special_d  = sp_hit;
                    spec_res_d = sp_res;
                    spec_inv_d = sp_inv;
                    spec_dz_d  = sp_dz;
                    spec_uf_d  = a_flush | b_flush;
                end
            end
            ST_DIVIDE: begin
                rem_d = {rem_sub[23:0], 1'b0};
                quo_d = {quo_q[25:0], q_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d = ST_IDLE;
                vout_d  = 1'b1;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                inx_d   = 1'b0;
                inv_d   = 1'b0;
                dz_d    = 1'b0;
                if (special_q) begin
                    out_d = spec_res_q;
                    inv_d = spec_inv_q;
                    dz_d  = spec_dz_q;
                    unf_d = spec_uf_q;
                end else if (fin_exp > 10'sd254) begin
                    out_d = ovf_res;
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end else if (fin_exp <= 10'sd0) begin
                    out_d = {sign_q, 31'd0};
                    unf_d = 1'b1;
                    inx_d = 1'b1;
                end else begin
                    out_d = {sign_q, fin_exp[7:0], rnd_mant};
                    inx_d = rnd_inexact;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            sign_q     <= 1'b0;
            rm_q       <= RM_RNE;
            div_q      <= 24'd0;
            rem_q      <= 25'd0;
            quo_q      <= 27'd0;
            exp_q      <= 10'sd0;
            special_q  <= 1'b0;
            spec_res_q <= 32'd0;
            spec_inv_q <= 1'b0;
            spec_dz_q  <= 1'b0;
            spec_uf_q  <= 1'b0;
            out_q      <= 32'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            inx_q      <= 1'b0;
            inv_q      <= 1'b0;
            dz_q       <= 1'b0;
            vout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            rm_q       <= rm_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            spec_inv_q <= spec_inv_d;
            spec_dz_q  <= spec_dz_d;
            spec_uf_q  <= spec_uf_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            inx_q      <= inx_d;
            inv_q      <= inv_d;
            dz_q       <= dz_d;
            vout_q     <= vout_d;
        end
    end

    assign ready             = (state_q == ST_IDLE);
    assign out               = out_q;
    assign overflow          = ovf_q;
    assign underflow         = unf_q;
    assign inexact           = inx_q;
    assign invalid_operation = inv_q;
    assign divide_by_zero    = dz_q;
    assign valid_data_out    = vout_q;

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Directed and randomized checks of fp_divide_iterative against an exact-division reference model.
module tb_fp_divide_iterative;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_data_in = 1'b0;
    logic        ready;
    logic [31:0] in1 = 32'd0;
    logic [31:0] in2 = 32'd0;
    logic [2:0]  rounding_mode = 3'd0;
    logic [31:0] dut_out;
    logic        overflow, underflow, inexact, invalid_operation, divide_by_zero;
    logic        valid_data_out;

    int errors = 0;
    int checks = 0;

    fp_divide_iterative dut (
        .clk               (clk),
        .rst               (rst),
        .valid_data_in     (valid_data_in),
        .ready             (ready),
        .in1               (in1),
        .in2               (in2),
        .rounding_mode     (rounding_mode),
        .out               (dut_out),
        .overflow          (overflow),
        .underflow         (underflow),
        .inexact           (inexact),
        .invalid_operation (invalid_operation),
        .divide_by_zero    (divide_by_zero),
        .valid_data_out    (valid_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {overflow, underflow, inexact, invalid_operation, divide_by_zero};
    endfunction

    // Reference: exact integer quotient of the significands, rounded by comparing the discarded
    // part against one half ulp. Flags are {overflow, underflow, inexact, invalid, div_by_zero}.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                                  output logic [31:0] r, output logic [4:0] f);
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        logic s;
        bit az, bz, ai, bi, an, bn, flush, special;
        longint num, qq, rm, sig, rb, half;
        bit lost, above, tie, up;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0]; fb = b[22:0];
        s  = a[31] ^ b[31];
        az = (ea == 0); bz = (eb == 0);
        ai = (ea == 255) && (fa == 0); bi = (eb == 255) && (fb == 0);
        an = (ea == 255) && (fa != 0); bn = (eb == 255) && (fb != 0);
        flush = (az && fa != 0) || (bz && fb != 0);
        special = 1'b1;
        f = 5'b0;
        r = 32'd0;
        if (an && fa[22])            r = a;
        else if (bn && fb[22])       r = b;
        else if (an)                 begin r = a | 32'h00400000; f[1] = 1'b1; end
        else if (bn)                 begin r = b | 32'h00400000; f[1] = 1'b1; end
        else if ((az && bz) || (ai && bi)) begin r = {s, 31'h7FC00000}; f[1] = 1'b1; end
        else if (ai)                 r = {s, 31'h7F800000};
        else if (bz)                 begin r = {s, 31'h7F800000}; f[0] = 1'b1; end
        else if (az || bi)           r = {s, 31'd0};
        else                         special = 1'b0;
        if (special) begin
            f[3] = flush;
            return;
        end
        num = longint'({1'b1, fa}) << 26;
        qq  = num / longint'({1'b1, fb});
        rm  = num % longint'({1'b1, fb});
        e   = ea - eb + 127;
        sh  = 3;
        if (qq < (longint'(1) << 26)) begin sh = 2; e = e - 1; end
        sig   = qq >> sh;
        rb    = qq & ((longint'(1) << sh) - 1);
        half  = longint'(1) << (sh - 1);
        lost  = (rb != 0) || (rm != 0);
        above = (rb > half) || (rb == half && rm != 0);
        tie   = (rb == half) && (rm == 0);
        case (m)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = s && lost;
            RM_RUP:  up = !s && lost;
            RM_RMM:  up = above || tie;
            default: up = above || (tie && sig[0]);
        endcase
        if (up) sig = sig + 1;
        if (sig == (longint'(1) << 24)) begin sig = longint'(1) << 23; e = e + 1; end
        if (e > 254) begin
            f = 5'b10100;
            case (m)
                RM_RTZ:  r = {s, 31'h7F7FFFFF};
                RM_RDN:  r = s ? 32'hFF800000 : 32'h7F7FFFFF;
                RM_RUP:  r = s ? 32'hFF7FFFFF : 32'h7F800000;
                default: r = {s, 31'h7F800000};
            endcase
        end else if (e <= 0) begin
            r = {s, 31'd0};
            f = 5'b01100;
        end else begin
            r = {s, 8'(e), sig[22:0]};
            f = {2'b00, lost, 2'b00};
        end
    endfunction

    function automatic logic [31:0] gen_operand();
        logic s;
        s = 1'($urandom);
        case ($urandom_range(0, 19))
            0:       return {s, 31'd0};
            1:       return {s, 31'h7F800000};
            2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
            3:       return {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
            4:       return {s, 8'h00, 23'($urandom) | 23'd1};
            5:       return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
            default: return {s, 8'($urandom_range(87, 167)), 23'($urandom)};
        endcase
    endfunction

    task automatic no_strobe(input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_data_out) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                          input logic [31:0] eo, input logic [4:0] ef, input string tag,
                          input bit pulse_mid);
        int lat;
        bit busy_ok;
        @(negedge clk);
        check($sformatf("%s/ready_idle", tag), {31'd0, ready}, 32'd1);
        in1 = a; in2 = b; rounding_mode = m; valid_data_in = 1'b1;
        @(posedge clk); #1;
        valid_data_in = 1'b0;
        in1 = $urandom; in2 = $urandom; rounding_mode = 3'($urandom_range(0, 4));
        lat = 0;
        busy_ok = 1'b1;
        while (valid_data_out !== 1'b1 && lat < 40) begin
            if (ready !== 1'b0) busy_ok = 1'b0;
            if (pulse_mid && lat == 10) valid_data_in = 1'b1;
            if (pulse_mid && lat == 11) valid_data_in = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s/latency", tag), lat, 28);
        check($sformatf("%s/busy", tag), {31'd0, busy_ok}, 32'd1);
        check($sformatf("%s/out", tag), dut_out, eo);
        check($sformatf("%s/flags", tag), {27'd0, flags_now()}, {27'd0, ef});
        @(posedge clk); #1;
        check($sformatf("%s/strobe_width", tag), {31'd0, valid_data_out}, 32'd0);
        check($sformatf("%s/out_hold", tag), dut_out, eo);
    endtask

    initial begin
        logic [31:0] ra, rb_op, ro;
        logic [4:0]  rf;
        logic [2:0]  rmode;
        int lat;

        #1;
        check("reset/ready", {31'd0, ready}, 32'd1);
        check("reset/out", dut_out, 32'd0);
        check("reset/valid", {31'd0, valid_data_out}, 32'd0);
        check("reset/flags", {27'd0, flags_now()}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40C00000, 32'h40000000, RM_RNE, 32'h40400000, 5'b00000, "6div2", 1'b0);
        run_op(32'h3F800000, 32'h40400000, RM_RNE, 32'h3EAAAAAB, 5'b00100, "1div3_rne", 1'b0);
        run_op(32'h3F800000, 32'h40400000, RM_RTZ, 32'h3EAAAAAA, 5'b00100, "1div3_rtz", 1'b0);
        run_op(32'h3F800000, 32'h00000000, RM_RNE, 32'h7F800000, 5'b00001, "1div0", 1'b0);
        run_op(32'h00000000, 32'h00000000, RM_RNE, 32'h7FC00000, 5'b00010, "0div0", 1'b0);
        run_op(32'h7F800001, 32'h3F800000, RM_RNE, 32'h7FC00001, 5'b00010, "snan", 1'b0);
        run_op(32'h00000001, 32'h3F800000, RM_RNE, 32'h00000000, 5'b01000, "denorm", 1'b0);
        run_op(32'h7F000000, 32'h3E800000, RM_RNE, 32'h7F800000, 5'b10100, "ovf_rne", 1'b0);
        run_op(32'h7F000000, 32'h3E800000, RM_RTZ, 32'h7F7FFFFF, 5'b10100, "ovf_rtz", 1'b0);
        run_op(32'hFF000000, 32'h3E800000, RM_RUP, 32'hFF7FFFFF, 5'b10100, "ovf_rup_neg", 1'b0);
        run_op(32'hFF000000, 32'h3E800000, RM_RDN, 32'hFF800000, 5'b10100, "ovf_rdn_neg", 1'b0);
        run_op(32'h00800000, 32'h4B000000, RM_RNE, 32'h00000000, 5'b01100, "unf", 1'b0);

        // A valid pulse while busy must be dropped.
        run_op(32'h40C00000, 32'h40000000, RM_RNE, 32'h40400000, 5'b00000, "pulse_busy", 1'b1);
        no_strobe(35, "pulse_busy/no_extra");

        // valid_data_in held high: accepts at E0 and again at E0+29.
        @(negedge clk);
        in1 = 32'h40C00000; in2 = 32'h40000000; rounding_mode = RM_RNE; valid_data_in = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (valid_data_out !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("held/first_latency", lat, 28);
        check("held/ready_at_strobe", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;
        lat = 1;
        while (valid_data_out !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        valid_data_in = 1'b0;
        check("held/second_gap", lat, 29);
        check("held/out", dut_out, 32'h40400000);
        @(posedge clk); #1;
        check("held/idle_after", {31'd0, ready}, 32'd1);

        // Reset in the middle of an operation aborts it.
        run_op(32'h3F800000, 32'h40400000, RM_RNE, 32'h3EAAAAAB, 5'b00100, "pre_rst", 1'b0);
        @(negedge clk);
        in1 = 32'h7F000000; in2 = 32'h3E800000; rounding_mode = RM_RNE; valid_data_in = 1'b1;
        @(posedge clk); #1;
        valid_data_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst/out", dut_out, 32'd0);
        check("midrst/flags", {27'd0, flags_now()}, 32'd0);
        check("midrst/ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        no_strobe(35, "midrst/no_strobe");

        for (int i = 0; i < 40; i++) begin
            ra    = gen_operand();
            rb_op = gen_operand();
            rmode = 3'($urandom_range(0, 4));
            model(ra, rb_op, rmode, ro, rf);
            run_op(ra, rb_op, rmode, ro, rf, $sformatf("rand%0d_%h_%h_m%0d", i, ra, rb_op, rmode), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
